// File: rtl/toilet_dose_sequencer_pkg.sv
// Shared types and constants for the smart-toilet fluid sequencers.
// Phase order is kept here so a future flush/sampler sequencer walks the same list.
package toilet_ctrl_pkg;

  localparam int CNT_W    = 16;
  localparam int N_PHASES = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DOSE3  = 3'd1;
  localparam logic [2:0] S_DOSE2  = 3'd2;
  localparam logic [2:0] S_DOSE1  = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_DOSE3  = S_DOSE3,
    ST_DOSE2  = S_DOSE2,
    ST_DOSE1  = S_DOSE1,
    ST_SETTLE = S_SETTLE,
    ST_DONE   = S_DONE
  } seq_state_t;

  localparam seq_state_t PHASE_ORDER [N_PHASES] = '{ST_DOSE3, ST_DOSE2, ST_DOSE1, ST_SETTLE};

  // Lowest phase index >= from whose count is nonzero; N_PHASES when none remain.
  function automatic logic [2:0] next_phase_idx(input logic [N_PHASES-1:0] nz,
                                                input logic [2:0] from);
    next_phase_idx = 3'(N_PHASES);
    for (int i = N_PHASES - 1; i >= 0; i--) begin
      if (i >= int'(from) && nz[i]) next_phase_idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/toilet_dose_sequencer_if.sv
// Control/status bundle between a run requester and the dose sequencer.
interface toilet_dose_sequencer_if #(parameter int CNT_W = toilet_ctrl_pkg::CNT_W);

  logic             start;
  logic             abort;
  logic [CNT_W-1:0] dose3_cycles;
  logic [CNT_W-1:0] dose2_cycles;
  logic [CNT_W-1:0] dose1_cycles;
  logic [CNT_W-1:0] settle_cycles;
  logic             valve_soln3;
  logic             valve_soln2;
  logic             valve_soln1;
  logic             busy;
  logic             done;
  logic             aborted;

  modport master (
    output start, abort, dose3_cycles, dose2_cycles, dose1_cycles, settle_cycles,
    input  valve_soln3, valve_soln2, valve_soln1, busy, done, aborted
  );

  modport slave (
    input  start, abort, dose3_cycles, dose2_cycles, dose1_cycles, settle_cycles,
    output valve_soln3, valve_soln2, valve_soln1, busy, done, aborted
  );

endinterface

// File: rtl/toilet_dose_sequencer_phase_timer.sv
// Loadable down-counter; holds at zero and flags it so the FSM can advance.
module phase_timer
  import toilet_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         cnt_zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/toilet_dose_sequencer.sv
// Timed inlet-valve sequencer: soln3, soln2, soln1 doses, then settle, then done.
//   state  | meaning
//   IDLE   | waiting for start; counts not yet captured
//   DOSE3  | soln3 valve open
//   DOSE2  | soln2 valve open
//   DOSE1  | soln1 valve open
//   SETTLE | all valves shut, waiting for the network to settle
//   DONE   | one-cycle completion marker
module toilet_dose_sequencer
  import toilet_ctrl_pkg::*;
(
  input logic                   clk,
  input logic                   rst_n,
  toilet_dose_sequencer_if.slave bus
);

  seq_state_t          state_q, state_d;
  logic [CNT_W-1:0]    shadow_q [N_PHASES];
  logic [CNT_W-1:0]    req_cnt  [N_PHASES];
  logic [CNT_W-1:0]    src_cnt  [N_PHASES];
  logic [N_PHASES-1:0] nz;
  logic [2:0]          search_from;
  logic [2:0]          nxt_idx;
  logic                accept, advance, timer_load, cnt_zero, aborted_q;
  logic [CNT_W-1:0]    load_val;

  assign accept = (state_q == ST_IDLE) && bus.start && !bus.abort;

  // On the start cycle the shadows are not loaded yet, so phase selection uses the live inputs.
  always_comb begin
    req_cnt[0] = bus.dose3_cycles;
    req_cnt[1] = bus.dose2_cycles;
    req_cnt[2] = bus.dose1_cycles;
    req_cnt[3] = bus.settle_cycles;
    for (int i = 0; i < N_PHASES; i++) begin
      src_cnt[i] = (state_q == ST_IDLE) ? req_cnt[i] : shadow_q[i];
      nz[i]      = (src_cnt[i] != '0);
    end
  end

  always_comb begin
    case (state_q)
      ST_DOSE3:  search_from = 3'd1;
      ST_DOSE2:  search_from = 3'd2;
      ST_DOSE1:  search_from = 3'd3;
      ST_SETTLE: search_from = 3'd4;
      default:   search_from = 3'd0;
    endcase
  end

  assign nxt_idx = next_phase_idx(nz, search_from);

  always_comb begin
    state_d    = state_q;
    advance    = 1'b0;
    timer_load = 1'b0;
    load_val   = '0;
    case (state_q)
      ST_IDLE:  advance = accept;
      ST_DOSE3, ST_DOSE2, ST_DOSE1, ST_SETTLE: begin
        if (bus.abort)     state_d = ST_IDLE;
        else if (cnt_zero) advance = 1'b1;
      end
      default:  state_d = ST_IDLE;
    endcase
    if (advance) begin
      if (nxt_idx == 3'(N_PHASES)) begin
        state_d = ST_DONE;
      end else begin
        state_d    = PHASE_ORDER[nxt_idx[1:0]];
        timer_load = 1'b1;
        load_val   = src_cnt[nxt_idx[1:0]] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      aborted_q <= 1'b0;
      for (int i = 0; i < N_PHASES; i++) shadow_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      aborted_q <= (state_q != ST_IDLE) && bus.abort;
      if (accept) begin
        for (int i = 0; i < N_PHASES; i++) shadow_q[i] <= req_cnt[i];
      end
    end
  end

  phase_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (load_val),
    .cnt_zero (cnt_zero)
  );

  assign bus.valve_soln3 = (state_q == ST_DOSE3);
  assign bus.valve_soln2 = (state_q == ST_DOSE2);
  assign bus.valve_soln1 = (state_q == ST_DOSE1);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.aborted     = aborted_q;

endmodule

// File: tb/tb_toilet_dose_sequencer.sv
// Scoreboard bench: each run pushes its expected completion/abort record, a negedge monitor checks it.
module tb_toilet_dose_sequencer;
  import toilet_ctrl_pkg::*;

  typedef struct {
    bit              is_abort;
    int              evt_cyc;
    logic [2:0][31:0] first;
    logic [2:0][31:0] last;
    logic [2:0][31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   n_events = 0;
  exp_t q[$];

  toilet_dose_sequencer_if #(.CNT_W(CNT_W)) bus();

  toilet_dose_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: phases occupy consecutive cycle ranges starting at relative cycle 1,
  // an abort sampled in cycle a truncates everything after a and reports in a+1.
  function automatic exp_t model(input int s, input int n3, input int n2, input int n1,
                                 input int ns, input int a);
    exp_t e;
    int lo[3];
    int hi[3];
    int t, lim, lst;
    lo[0] = 1;           hi[0] = n3;
    lo[1] = n3 + 1;      hi[1] = n3 + n2;
    lo[2] = n3 + n2 + 1; hi[2] = n3 + n2 + n1;
    t   = n3 + n2 + n1 + ns + 1;
    lim = (a > 0) ? a : t;
    e.is_abort = (a > 0);
    e.evt_cyc  = s - 1 + ((a > 0) ? a + 1 : t);
    for (int v = 0; v < 3; v++) begin
      lst = (hi[v] < lim) ? hi[v] : lim;
      if (lst >= lo[v]) begin
        e.cnt[v]   = 32'(lst - lo[v] + 1);
        e.first[v] = 32'(s - 1 + lo[v]);
        e.last[v]  = 32'(s - 1 + lst);
      end else begin
        e.cnt[v]   = '0;
        e.first[v] = '0;
        e.last[v]  = '0;
      end
    end
    return e;
  endfunction

  // Monitor
  logic [2:0] vv;
  int   tf[3];
  int   tl[3];
  int   tn[3];
  bit   busy_low_due = 1'b0;
  exp_t me;

  initial for (int i = 0; i < 3; i++) begin tf[i] = 0; tl[i] = 0; tn[i] = 0; end

  always @(negedge clk) begin
    vv = {bus.valve_soln1, bus.valve_soln2, bus.valve_soln3};
    chk("valve_onehot", int'($countones(vv) > 1), 0);
    for (int i = 0; i < 3; i++) begin
      if (vv[i]) begin
        if (tn[i] == 0) tf[i] = cyc;
        tl[i] = cyc;
        tn[i]++;
      end
    end
    if (busy_low_due) begin
      chk("busy_after_done", int'(bus.busy), 0);
      busy_low_due = 1'b0;
    end
    if (bus.done || bus.aborted) begin
      n_events++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: done=%0d aborted=%0d with nothing expected (cycle %0d)",
                 bus.done, bus.aborted, cyc);
      end else begin
        me = q.pop_front();
        chk("event_aborted", int'(bus.aborted), int'(me.is_abort));
        chk("event_done", int'(bus.done), int'(!me.is_abort));
        chk("event_cycle", cyc, me.evt_cyc);
        chk("busy_at_event", int'(bus.busy), me.is_abort ? 0 : 1);
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("valve_soln%0d_len", 3 - i), tn[i], int'(me.cnt[i]));
          if (me.cnt[i] != 0) begin
            chk($sformatf("valve_soln%0d_first", 3 - i), tf[i], int'(me.first[i]));
            chk($sformatf("valve_soln%0d_last", 3 - i), tl[i], int'(me.last[i]));
          end
        end
      end
      if (bus.done) busy_low_due = 1'b1;
    end
    if (!bus.busy) begin
      for (int i = 0; i < 3; i++) begin tf[i] = 0; tl[i] = 0; tn[i] = 0; end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_events(input int target, input int budget);
    int k = 0;
    while (n_events < target && k < budget) begin
      next_cyc();
      k++;
    end
    if (n_events < target) begin
      checks++;
      failures++;
      $display("FAIL event_timeout: saw %0d events, required %0d within %0d cycles",
               n_events, target, budget);
    end
  endtask

  task automatic set_counts(input int n3, input int n2, input int n1, input int ns);
    bus.dose3_cycles  = CNT_W'(n3);
    bus.dose2_cycles  = CNT_W'(n2);
    bus.dose1_cycles  = CNT_W'(n1);
    bus.settle_cycles = CNT_W'(ns);
  endtask

  task automatic run_seq(input int n3, input int n2, input int n1, input int ns, input int a);
    int s;
    int base;
    base = n_events;
    next_cyc();
    set_counts(n3, n2, n1, ns);
    bus.start = 1'b1;
    next_cyc();
    s = cyc;
    bus.start = 1'b0;
    set_counts($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
               $urandom_range(0, 9));
    q.push_back(model(s, n3, n2, n1, ns, a));
    if (a > 0) begin
      for (int k = 1; k < a; k++) next_cyc();
      bus.abort = 1'b1;
      next_cyc();
      bus.abort = 1'b0;
    end
    wait_events(base + 1, n3 + n2 + n1 + ns + 12);
  endtask

  initial begin
    int a3, a2, a1, as, b3, b2, b1, bs, ta, tb_len, s, base, t, ab;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_counts(0, 0, 0, 0);
    repeat (3) next_cyc();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_aborted", int'(bus.aborted), 0);
    chk("rst_valves", int'({bus.valve_soln3, bus.valve_soln2, bus.valve_soln1}), 0);
    rst_n = 1'b1;

    run_seq(4, 2, 3, 5, 0);
    run_seq(2, 0, 0, 0, 0);
    run_seq(0, 0, 0, 0, 0);
    run_seq(10, 1, 1, 1, 3);
    run_seq(0, 3, 0, 2, 0);
    run_seq(1, 1, 1, 1, 4);

    // Reset in the middle of DOSE2: no event may follow.
    next_cyc();
    set_counts(2, 5, 1, 1);
    bus.start = 1'b1;
    next_cyc();
    bus.start = 1'b0;
    base = n_events;
    for (int k = 1; k < 4; k++) next_cyc();
    chk("pre_rst_valve_soln2", int'(bus.valve_soln2), 1);
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_outputs", int'({bus.valve_soln3, bus.valve_soln2, bus.valve_soln1,
                                bus.done, bus.aborted}), 0);
    repeat (15) next_cyc();
    chk("midrst_no_event", n_events, base);

    // Abort alone and start+abort together in IDLE are both ignored.
    base = n_events;
    bus.abort = 1'b1;
    next_cyc();
    chk("idle_abort_busy", int'(bus.busy), 0);
    bus.start = 1'b1;
    next_cyc();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_busy", int'(bus.busy), 0);
    repeat (3) next_cyc();
    chk("idle_abort_no_event", n_events, base);

    // Start held through a run with counts changed mid-run: back-to-back second run.
    a3 = $urandom_range(1, 5); a2 = $urandom_range(1, 5);
    a1 = $urandom_range(1, 5); as = $urandom_range(1, 5);
    b3 = $urandom_range(0, 5); b2 = $urandom_range(0, 5);
    b1 = $urandom_range(0, 5); bs = $urandom_range(0, 5);
    ta = a3 + a2 + a1 + as + 1;
    tb_len = b3 + b2 + b1 + bs + 1;
    base = n_events;
    next_cyc();
    set_counts(a3, a2, a1, as);
    bus.start = 1'b1;
    next_cyc();
    s = cyc;
    set_counts(b3, b2, b1, bs);
    q.push_back(model(s, a3, a2, a1, as, 0));
    q.push_back(model(s + ta + 1, b3, b2, b1, bs, 0));
    wait_events(base + 2, ta + tb_len + 20);
    bus.start = 1'b0;
    repeat (4) next_cyc();
    chk("hold_event_count", n_events, base + 2);

    // Randomized runs, some aborted part-way.
    for (int r = 0; r < 30; r++) begin
      a3 = $urandom_range(0, 5); a2 = $urandom_range(0, 5);
      a1 = $urandom_range(0, 5); as = $urandom_range(0, 5);
      t  = a3 + a2 + a1 + as + 1;
      ab = (t > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, t - 1) : 0;
      run_seq(a3, a2, a1, as, ab);
    end

    run_seq(0, 0, 65535, 0, 0);

    repeat (5) next_cyc();
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
